console_writer: RTL



---
 rtl/console_writer_pkg.sv | 27 ++
 rtl/console_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/console_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : console_writer_pkg
//  Description : Shared control codes, cell constants and writer state type
//                for the HDMI text console.
//  Revision    : 1.0  initial release
// ============================================================================
package console_writer_pkg;

    localparam logic [7:0] c_CR           = 8'h0D;
    localparam logic [7:0] c_LF           = 8'h0A;
    localparam logic [7:0] c_BS           = 8'h08;
    localparam logic [7:0] c_TAB          = 8'h09;
    localparam logic [7:0] c_FF           = 8'h0C;
    localparam logic [7:0] c_ESC          = 8'h1B;
    localparam logic [7:0] c_DEFAULT_ATTR = 8'h07;
    localparam logic [7:0] c_BLANK        = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ESC     = 2'd1,
        ST_CLR_ROW = 2'd2,
        ST_CLR_ALL = 2'd3
    } state_t;

endpackage : console_writer_pkg
`default_nettype wire

// File: rtl/console_writer.sv
`default_nettype none
// ============================================================================
//  Module      : console_writer
//  Description : Byte-stream to text-RAM cell writer with cursor, attribute
//                and circular-scroll handling.
//  Revision    : 1.0  initial release
// ============================================================================
module console_writer
    import console_writer_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ch,
    input  logic                    ch_valid,
    output logic                    ch_ready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [15:0]             wr_data,
    output logic [$clog2(ROWS)-1:0] scroll_row,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int TAB_W = COL_W + 1;
    localparam int CNT_W = ADDR_WIDTH + 1;

    state_t                r_state, w_state_nxt;
    logic [COL_W-1:0]      r_col, w_col_nxt;
    logic [ROW_W-1:0]      r_row, w_row_nxt;
    logic [ROW_W-1:0]      r_scroll, w_scroll_nxt;
    logic [7:0]            r_attr, w_attr_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [15:0]           r_wr_data, w_wr_data_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
    logic [CNT_W-1:0]      r_clr_cnt, w_clr_cnt_nxt;

    logic                  w_accept;
    logic                  w_last_row;
    logic                  w_last_col;
    logic [ROW_W:0]        w_phys_sum;
    logic [ROW_W-1:0]      w_phys_row;
    logic [ROW_W-1:0]      w_scroll_inc;
    logic [ADDR_WIDTH-1:0] w_cell_addr;
    logic [ADDR_WIDTH-1:0] w_row_base;
    logic [TAB_W-1:0]      w_tab;

    assign ch_ready   = (r_state == ST_IDLE) || (r_state == ST_ESC);
    assign w_accept   = ch_valid && ch_ready;
    assign w_last_row = (r_row == ROW_W'(ROWS - 1));
    assign w_last_col = (r_col == COL_W'(COLS - 1));

    assign w_phys_sum   = {1'b0, r_row} + {1'b0, r_scroll};
    assign w_phys_row   = (w_phys_sum >= (ROW_W + 1)'(ROWS))
                        ? ROW_W'(w_phys_sum - (ROW_W + 1)'(ROWS))
                        : ROW_W'(w_phys_sum);
    assign w_scroll_inc = (r_scroll == ROW_W'(ROWS - 1)) ? '0 : r_scroll + 1'b1;
    assign w_cell_addr  = ADDR_WIDTH'(w_phys_row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(r_col);
    // After a scroll the new bottom physical row is the old top row.
    assign w_row_base   = ADDR_WIDTH'(r_scroll) * ADDR_WIDTH'(COLS);

    always_comb begin
        w_tab = ({1'b0, r_col} | TAB_W'(7)) + TAB_W'(1);
        if (w_tab > TAB_W'(COLS - 1)) begin
            w_tab = TAB_W'(COLS - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_scroll   <= '0;
            r_attr     <= c_DEFAULT_ATTR;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_clr_addr <= '0;
            r_clr_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_scroll   <= w_scroll_nxt;
            r_attr     <= w_attr_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_scroll_nxt   = r_scroll;
        w_attr_nxt     = r_attr;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_cnt_nxt  = r_clr_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (ch >= c_BLANK) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = w_cell_addr;
                        w_wr_data_nxt = {r_attr, ch};
                        if (w_last_col) begin
                            w_col_nxt = '0;
                            if (w_last_row) begin
                                // Character goes out now; the whole row clear follows it.
                                w_scroll_nxt   = w_scroll_inc;
                                w_state_nxt    = ST_CLR_ROW;
                                w_clr_addr_nxt = w_row_base;
                                w_clr_cnt_nxt  = CNT_W'(COLS);
                            end else begin
                                w_row_nxt = r_row + 1'b1;
                            end
                        end else begin
                            w_col_nxt = r_col + 1'b1;
                        end
                    end else begin
                        case (ch)
                            c_CR: w_col_nxt = '0;
                            c_LF: begin
                                if (w_last_row) begin
                                    w_scroll_nxt   = w_scroll_inc;
                                    w_state_nxt    = ST_CLR_ROW;
                                    w_wr_en_nxt    = 1'b1;
                                    w_wr_addr_nxt  = w_row_base;
                                    w_wr_data_nxt  = {r_attr, c_BLANK};
                                    w_clr_addr_nxt = w_row_base + 1'b1;
                                    w_clr_cnt_nxt  = CNT_W'(COLS - 1);
                                end else begin
                                    w_row_nxt = r_row + 1'b1;
                                end
                            end
                            c_BS: begin
                                if (r_col != '0) begin
                                    w_col_nxt = r_col - 1'b1;
                                end
                            end
                            c_TAB: w_col_nxt = COL_W'(w_tab);
                            c_FF: begin
                                w_col_nxt      = '0;
                                w_row_nxt      = '0;
                                w_scroll_nxt   = '0;
                                w_state_nxt    = ST_CLR_ALL;
                                w_wr_en_nxt    = 1'b1;
                                w_wr_addr_nxt  = '0;
                                w_wr_data_nxt  = {r_attr, c_BLANK};
                                w_clr_addr_nxt = ADDR_WIDTH'(1);
                                w_clr_cnt_nxt  = CNT_W'(COLS * ROWS - 1);
                            end
                            c_ESC:   w_state_nxt = ST_ESC;
                            default: ;
                        endcase
                    end
                end
            end

            ST_ESC: begin
                if (w_accept) begin
                    w_attr_nxt  = ch;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_CLR_ROW, ST_CLR_ALL: begin
                if (r_clr_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wr_en_nxt    = 1'b1;
                    w_wr_addr_nxt  = r_clr_addr;
                    w_wr_data_nxt  = {r_attr, c_BLANK};
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                    w_clr_cnt_nxt  = r_clr_cnt - 1'b1;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign scroll_row = r_scroll;
    assign cursor_col = r_col;
    assign cursor_row = r_row;

endmodule : console_writer
`default_nettype wire
